// File: rtl/pipe_share_arb_if.sv
// pipe_share_arb_if
//   Requester-side bus of the shared-pipeline arbiter: per-requester beat
//   handshake plus the broadcast response channel.
//   slave  : arbiter view (consumes beats, produces ready and responses)
//   master : requester view
//   req_valid_i   [NUM_REQ]          per-requester beat valid
//   req_last_i    [NUM_REQ]          per-requester last beat of burst
//   req_data_i    [NUM_REQ*DATA_W]   packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_status_i  [NUM_REQ*STATUS_W] packed status, same packing
//   req_ready_o   [NUM_REQ]          beat accepted when valid & ready
//   rsp_valid_o   [NUM_REQ]          one-hot owner of the returned beat
//   rsp_data_o    [DATA_W]           returned payload (broadcast)
//   rsp_status_o  [STATUS_W]         returned status (broadcast)
interface pipe_share_arb_if #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 32,
  parameter int STATUS_W = 1
);
  logic [NUM_REQ-1:0]          req_valid_i;
  logic [NUM_REQ-1:0]          req_last_i;
  logic [NUM_REQ*DATA_W-1:0]   req_data_i;
  logic [NUM_REQ*STATUS_W-1:0] req_status_i;
  logic [NUM_REQ-1:0]          req_ready_o;
  logic [NUM_REQ-1:0]          rsp_valid_o;
  logic [DATA_W-1:0]           rsp_data_o;
  logic [STATUS_W-1:0]         rsp_status_o;

  modport slave (
    input  req_valid_i, req_last_i, req_data_i, req_status_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o
  );

  modport master (
    output req_valid_i, req_last_i, req_data_i, req_status_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o
  );
endinterface

// File: rtl/pipe_share_arb.sv
// pipe_share_arb
//   Round-robin arbiter in front of a shared fixed-latency data/status
//   pipeline. Accepted beats are registered into the pipeline; an owner tag
//   travels alongside so the returned beat can be steered back (one-hot
//   rsp_valid_o) PIPE_DEPTH+1 cycles after acceptance.
//   Optional burst lock: define PIPE_SHARE_ARB_LOCK_EN to hold the grant on
//   one requester until it presents req_last_i. Without it req_last_i is
//   ignored and every beat is re-arbitrated.
// Ports
//   clk           rising-edge clock
//   rst_n         synchronous active-low reset
//   req_bus       requester bus (slave modport of pipe_share_arb_if)
//   pipe_data_o   / pipe_status_o  shared pipeline inputs (registered)
//   pipe_data_i   / pipe_status_i  shared pipeline outputs
//   drain_i       stop granting and let the pipeline empty
//   idle_o        nothing in flight and nothing being granted
module pipe_share_arb #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = 32,
  parameter int STATUS_W   = 1,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_share_arb_if.slave     req_bus,
  output logic [DATA_W-1:0]   pipe_data_o,
  output logic [STATUS_W-1:0] pipe_status_o,
  input  logic [DATA_W-1:0]   pipe_data_i,
  input  logic [STATUS_W-1:0] pipe_status_i,
  input  logic                drain_i,
  output logic                idle_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    ST_ARB   = 2'd0,
    ST_LOCK  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [IDX_W-1:0]    ptr_r;
  logic [IDX_W-1:0]    ptr_nxt_s;
  logic [SUM_W-1:0]    sum_s;
  logic                rr_found_s;
  logic [IDX_W-1:0]    rr_idx_s;
  logic                grant_en_s;
  logic [IDX_W-1:0]    gnt_idx_s;
  logic                accept_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [STATUS_W-1:0] sel_status_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic [NUM_REQ-1:0]  rsp_valid_s;
  logic [STATUS_W-1:0] rsp_status_s;
  logic [PIPE_DEPTH:0] tag_vld_r;
  logic [IDX_W-1:0]    tag_own_r [PIPE_DEPTH+1];

`ifdef PIPE_SHARE_ARB_LOCK_EN
  logic                sel_last_s;
  logic [IDX_W-1:0]    lock_own_r;
`else
  logic                unused_last_s;
  assign unused_last_s = ^req_bus.req_last_i;
`endif

  // Successor of a requester index with wrap at NUM_REQ-1.
  function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
    if (idx == IDX_W'(NUM_REQ - 1)) begin
      return '0;
    end else begin
      return idx + IDX_W'(1);
    end
  endfunction

  // Round-robin search: first valid requester at or after the pointer.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = '0;
    sum_s      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + SUM_W'(k);
      if (sum_s >= SUM_W'(NUM_REQ)) begin
        sum_s = sum_s - SUM_W'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      if (!rr_found_s && req_bus.req_valid_i[sum_s[IDX_W-1:0]]) begin
        rr_found_s = 1'b1;
        rr_idx_s   = sum_s[IDX_W-1:0];
      end else begin
        rr_found_s = rr_found_s;
      end
    end
  end

  // Grant decision per state; a locked owner is served only while valid.
  always_comb begin
    grant_en_s = 1'b0;
    gnt_idx_s  = rr_idx_s;
    case (state_r)
      ST_ARB: begin
        if (drain_i) begin
          grant_en_s = 1'b0;
        end else begin
          grant_en_s = rr_found_s;
        end
      end
      ST_LOCK: begin
`ifdef PIPE_SHARE_ARB_LOCK_EN
        gnt_idx_s  = lock_own_r;
        grant_en_s = req_bus.req_valid_i[lock_own_r];
`else
        grant_en_s = 1'b0;
`endif
      end
      ST_DRAIN: grant_en_s = 1'b0;
      default:  grant_en_s = 1'b0;
    endcase
  end

  // Nothing is accepted while reset is asserted.
  assign accept_s = rst_n && grant_en_s;

  // Select payload/status (and last flag) of the granted requester.
  always_comb begin
    sel_data_s   = '0;
    sel_status_s = '0;
`ifdef PIPE_SHARE_ARB_LOCK_EN
    sel_last_s   = 1'b0;
`endif
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx_s == IDX_W'(i)) begin
        sel_data_s   = req_bus.req_data_i[i*DATA_W +: DATA_W];
        sel_status_s = req_bus.req_status_i[i*STATUS_W +: STATUS_W];
`ifdef PIPE_SHARE_ARB_LOCK_EN
        sel_last_s   = req_bus.req_last_i[i];
`endif
      end else begin
        sel_data_s   = sel_data_s;
      end
    end
  end

  // One-hot ready to the granted requester.
  always_comb begin
    ready_s = '0;
    if (accept_s) begin
      ready_s[gnt_idx_s] = 1'b1;
    end else begin
      ready_s = '0;
    end
  end

  // Next state and round-robin pointer.
  always_comb begin
    state_nxt_s = state_r;
    ptr_nxt_s   = ptr_r;
    case (state_r)
      ST_ARB: begin
        if (drain_i) begin
          state_nxt_s = ST_DRAIN;
`ifdef PIPE_SHARE_ARB_LOCK_EN
        end else if (accept_s && !sel_last_s) begin
          state_nxt_s = ST_LOCK;
`endif
        end else begin
          state_nxt_s = ST_ARB;
        end
      end
      ST_LOCK: begin
`ifdef PIPE_SHARE_ARB_LOCK_EN
        if (accept_s && sel_last_s) begin
          state_nxt_s = drain_i ? ST_DRAIN : ST_ARB;
        end else begin
          state_nxt_s = ST_LOCK;
        end
`else
        state_nxt_s = ST_ARB;
`endif
      end
      ST_DRAIN: state_nxt_s = drain_i ? ST_DRAIN : ST_ARB;
      default:  state_nxt_s = ST_ARB;
    endcase
    // Pointer moves past the owner only when a burst (or single beat) ends.
`ifdef PIPE_SHARE_ARB_LOCK_EN
    if (accept_s && sel_last_s) begin
`else
    if (accept_s) begin
`endif
      ptr_nxt_s = inc_idx(gnt_idx_s);
    end else begin
      ptr_nxt_s = ptr_r;
    end
  end

  // Control state, tag valids and pipeline status (reset domain).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= ST_ARB;
      ptr_r         <= '0;
      tag_vld_r     <= '0;
      pipe_status_o <= '0;
    end else begin
      state_r       <= state_nxt_s;
      ptr_r         <= ptr_nxt_s;
      tag_vld_r     <= {tag_vld_r[PIPE_DEPTH-1:0], accept_s};
      pipe_status_o <= accept_s ? sel_status_s : '0;
    end
  end

  // Payload register and owner tags are not reset; valids qualify them.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      pipe_data_o <= sel_data_s;
    end else begin
      pipe_data_o <= pipe_data_o;
    end
    tag_own_r[0] <= gnt_idx_s;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      tag_own_r[k] <= tag_own_r[k-1];
    end
  end

`ifdef PIPE_SHARE_ARB_LOCK_EN
  // Capture the burst owner on the beat that opens a lock.
  always_ff @(posedge clk) begin
    if (accept_s && (state_r == ST_ARB)) begin
      lock_own_r <= gnt_idx_s;
    end else begin
      lock_own_r <= lock_own_r;
    end
  end
`endif

  // Steer the returning beat to its owner using the oldest tag.
  always_comb begin
    rsp_valid_s  = '0;
    rsp_status_s = '0;
    if (tag_vld_r[PIPE_DEPTH]) begin
      rsp_valid_s[tag_own_r[PIPE_DEPTH]] = 1'b1;
      rsp_status_s                       = pipe_status_i;
    end else begin
      rsp_status_s = '0;
    end
  end

  assign req_bus.req_ready_o  = ready_s;
  assign req_bus.rsp_valid_o  = rsp_valid_s;
  assign req_bus.rsp_data_o   = pipe_data_i;
  assign req_bus.rsp_status_o = rsp_status_s;

  // Idle: not mid-burst, nothing in flight, nothing being accepted now.
  assign idle_o = !rst_n ||
                  (((state_r == ST_ARB) || (state_r == ST_DRAIN)) &&
                   (tag_vld_r == '0) && !accept_s);

endmodule

// File: tb/tb_pipe_share_arb.sv
// tb_pipe_share_arb
//   Two arbiters (PIPE_DEPTH 3 and 2) driven with identical requester
//   stimulus, each closing its shared pipeline through a bench delay line.
//   Directed vectors with hand-computed grants; responses, idle and pipeline
//   outputs are predicted from the expected grant history.
//   Honors PIPE_SHARE_ARB_LOCK_EN for the burst-lock expectations.
module tb_pipe_share_arb;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int SW = 1;
`ifdef PIPE_SHARE_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] valid;
    logic [3:0] last;
    logic       drain;
    logic [3:0] exp_ready;
  } vec_t;

  typedef struct {
    logic [3:0]  rdy;
    logic [31:0] data;
    logic        stat;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drain;
  logic [31:0] pdo3, pdi3, pdo2, pdi2;
  logic [0:0]  pso3, psi3, pso2, psi2;
  logic        idle3, idle2;
  logic [31:0] p3_data [3];
  logic        p3_stat [3];
  logic [31:0] p2_data [2];
  logic        p2_stat [2];

  int          checks = 0;
  int          failures = 0;
  beat_t       hist[$];
  logic [127:0] data_vec;
  logic [3:0]  stat_vec;
  logic [31:0] exp_pdata;
  logic        exp_pstat;
  bit          pdata_known;
  vec_t        vt [18];

  pipe_share_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .STATUS_W(SW)) bus3 ();
  pipe_share_arb_if #(.NUM_REQ(NR), .DATA_W(DW), .STATUS_W(SW)) bus2 ();

  pipe_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .STATUS_W(SW), .PIPE_DEPTH(3)) u_d3 (
    .clk(clk), .rst_n(rst_n), .req_bus(bus3.slave),
    .pipe_data_o(pdo3), .pipe_status_o(pso3),
    .pipe_data_i(pdi3), .pipe_status_i(psi3),
    .drain_i(drain), .idle_o(idle3)
  );

  pipe_share_arb #(.NUM_REQ(NR), .DATA_W(DW), .STATUS_W(SW), .PIPE_DEPTH(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .req_bus(bus2.slave),
    .pipe_data_o(pdo2), .pipe_status_o(pso2),
    .pipe_data_i(pdi2), .pipe_status_i(psi2),
    .drain_i(drain), .idle_o(idle2)
  );

  always #5 clk = ~clk;

  // Shared pipeline stand-ins: pure delay lines of the configured depth.
  always_ff @(posedge clk) begin
    p3_data[0] <= pdo3;
    p3_stat[0] <= pso3[0];
    p2_data[0] <= pdo2;
    p2_stat[0] <= pso2[0];
    for (int k = 1; k < 3; k++) begin
      p3_data[k] <= p3_data[k-1];
      p3_stat[k] <= p3_stat[k-1];
    end
    p2_data[1] <= p2_data[0];
    p2_stat[1] <= p2_stat[0];
  end

  assign pdi3 = p3_data[2];
  assign psi3 = p3_stat[2];
  assign pdi2 = p2_data[1];
  assign psi2 = p2_stat[1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic beat_t exp_rsp(input int d);
    beat_t b;
    int    idx;
    b.rdy  = 4'b0000;
    b.data = 32'h0000_0000;
    b.stat = 1'b0;
    idx = hist.size() - 1 - d;
    if (idx >= 0) b = hist[idx];
    return b;
  endfunction

  function automatic bit tags_empty(input int d);
    int idx;
    for (int k = 0; k <= d; k++) begin
      idx = hist.size() - 1 - k;
      if (idx >= 0 && hist[idx].rdy != 4'b0000) return 1'b0;
    end
    return 1'b1;
  endfunction

  // One clock: drive at the falling edge, check 1 time unit later.
  task automatic cycle(input logic [3:0] v, input logic [3:0] l, input logic d,
                       input logic r, input logic lk, input logic [3:0] er);
    beat_t e3, e2, nb;
    int    gi;
    @(negedge clk);
    bus3.req_valid_i  = v;        bus2.req_valid_i  = v;
    bus3.req_last_i   = l;        bus2.req_last_i   = l;
    bus3.req_data_i   = data_vec; bus2.req_data_i   = data_vec;
    bus3.req_status_i = stat_vec; bus2.req_status_i = stat_vec;
    drain = d;
    rst_n = r;
    #1;
    chk("ready_d3", {28'h0, bus3.req_ready_o}, {28'h0, er});
    chk("ready_d2", {28'h0, bus2.req_ready_o}, {28'h0, er});
    e3 = exp_rsp(3);
    e2 = exp_rsp(2);
    chk("rsp_valid_d3", {28'h0, bus3.rsp_valid_o}, {28'h0, e3.rdy});
    chk("rsp_valid_d2", {28'h0, bus2.rsp_valid_o}, {28'h0, e2.rdy});
    chk("rsp_status_d3", {31'h0, bus3.rsp_status_o}, {31'h0, (e3.rdy != 4'b0000) && e3.stat});
    chk("rsp_status_d2", {31'h0, bus2.rsp_status_o}, {31'h0, (e2.rdy != 4'b0000) && e2.stat});
    if (e3.rdy != 4'b0000) chk("rsp_data_d3", bus3.rsp_data_o, e3.data);
    if (e2.rdy != 4'b0000) chk("rsp_data_d2", bus2.rsp_data_o, e2.data);
    chk("idle_d3", {31'h0, idle3}, {31'h0, !r || (!lk && tags_empty(3) && er == 4'b0000)});
    chk("idle_d2", {31'h0, idle2}, {31'h0, !r || (!lk && tags_empty(2) && er == 4'b0000)});
    chk("pipe_status_d3", {31'h0, pso3}, {31'h0, exp_pstat});
    chk("pipe_status_d2", {31'h0, pso2}, {31'h0, exp_pstat});
    if (pdata_known) begin
      chk("pipe_data_d3", pdo3, exp_pdata);
      chk("pipe_data_d2", pdo2, exp_pdata);
    end
    gi = 0;
    for (int i = 0; i < 4; i++) if (er[i]) gi = i;
    nb.rdy  = er;
    nb.data = data_vec[gi*32 +: 32];
    nb.stat = stat_vec[gi];
    hist.push_back(nb);
    exp_pstat = (er != 4'b0000) ? nb.stat : 1'b0;
    if (er != 4'b0000) begin
      exp_pdata   = nb.data;
      pdata_known = 1'b1;
    end
    if (!r) begin
      for (int i = 0; i < hist.size(); i++) hist[i].rdy = 4'b0000;
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    drain       = 1'b0;
    data_vec    = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    stat_vec    = 4'b1010;
    exp_pdata   = 32'h0000_0000;
    exp_pstat   = 1'b0;
    pdata_known = 1'b0;
    bus3.req_valid_i = '0; bus3.req_last_i = '0; bus3.req_data_i = '0; bus3.req_status_i = '0;
    bus2.req_valid_i = '0; bus2.req_last_i = '0; bus2.req_data_i = '0; bus2.req_status_i = '0;

    for (int i = 0; i < 8; i++) vt[i] = '{4'hF, 4'hF, 1'b0, 4'b0001 << (i % 4)};
    vt[8]  = '{4'b1010, 4'hF, 1'b0, 4'b0010};
    vt[9]  = '{4'b1010, 4'hF, 1'b0, 4'b1000};
    vt[10] = '{4'b0110, 4'hF, 1'b0, 4'b0010};
    vt[11] = '{4'b0001, 4'hF, 1'b0, 4'b0001};
    vt[12] = '{4'b1001, 4'hF, 1'b0, 4'b1000};
    for (int i = 13; i < 18; i++) vt[i] = '{4'b0000, 4'hF, 1'b0, 4'b0000};

    // Reset with everyone requesting: no ready, idle, cleared status.
    cycle(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
    cycle(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);

    // Round-robin order and assorted sparse request patterns.
    for (int i = 0; i < 18; i++) begin
      cycle(vt[i].valid, vt[i].last, vt[i].drain, 1'b1, 1'b0, vt[i].exp_ready);
    end

    // Single beat from requester 2 through the depth-3 pipeline.
    data_vec[64 +: 32] = 32'hA5A5_A5A5;
    cycle(4'b0100, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0100);
    data_vec[64 +: 32] = 32'h3333_3333;
    cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("a5_pipe_data", pdo3, 32'hA5A5_A5A5);
    cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
    chk("a5_rsp_valid", {28'h0, bus3.rsp_valid_o}, 32'h0000_0004);
    chk("a5_rsp_data", bus3.rsp_data_o, 32'hA5A5_A5A5);

    // Drain with two beats in flight, then resume.
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b1000);
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 6; i++) begin
      cycle(4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 4'b0000);
      if (i == 2) begin
        chk("drain_last_rsp", {28'h0, bus2.rsp_valid_o}, 32'h0000_0001);
        chk("drain_not_idle", {31'h0, idle2}, 32'h0000_0000);
      end
      if (i == 3) begin
        chk("drain_rsp_fall", {28'h0, bus2.rsp_valid_o}, 32'h0000_0000);
        chk("drain_idle", {31'h0, idle2}, 32'h0000_0001);
      end
    end
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0010);
    for (int i = 0; i < 5; i++) cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);

    // Reset with two beats in flight: responses dropped, pointer back to 0.
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0100);
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b1000);
    cycle(4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 4'b0000);
    cycle(4'hF, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) begin
      cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);
      if (i < 2) begin
        chk("rst_drop_d3", {28'h0, bus3.rsp_valid_o}, 32'h0000_0000);
        chk("rst_drop_d2", {28'h0, bus2.rsp_valid_o}, 32'h0000_0000);
      end
    end

    // Burst from requester 1 against a steady requester 0.
    cycle(4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0010);
    cycle(4'b0011, 4'b0001, 1'b0, 1'b1, LOCK_EN, LOCK_EN ? 4'b0010 : 4'b0001);
    cycle(4'b0011, 4'b0011, 1'b0, 1'b1, LOCK_EN, 4'b0010);
    cycle(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001);

    // Same burst with a valid gap inside it.
    cycle(4'b0011, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0010);
    cycle(4'b0001, 4'b0001, 1'b0, 1'b1, LOCK_EN, LOCK_EN ? 4'b0000 : 4'b0001);
    cycle(4'b0001, 4'b0001, 1'b0, 1'b1, LOCK_EN, LOCK_EN ? 4'b0000 : 4'b0001);
    cycle(4'b0011, 4'b0011, 1'b0, 1'b1, LOCK_EN, 4'b0010);
    cycle(4'b0001, 4'b0001, 1'b0, 1'b1, 1'b0, 4'b0001);
    for (int i = 0; i < 5; i++) cycle(4'b0000, 4'hF, 1'b0, 1'b1, 1'b0, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
